// File: rtl/muon_event_buffer_pkg.sv
// Shared constants, FSM encoding and helpers for the muon event buffer.
package muon_event_buffer_pkg;

  // Sample width of the ADC0/ADC1/ADC2/ADC_SSD streams.
  localparam int ADC_WIDTH = 12;

  // Default buffer geometry.
  localparam int MUON_BUF_DEPTH     = 16;
  localparam int MUON_BUF_TS_WIDTH  = 24;
  localparam int MUON_BUF_WIN_WIDTH = 5;

  // Width of the saturating statistics counters.
  localparam int STAT_WIDTH = 16;

  // Capture FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_WRITE  = 2'd2
  } cap_state_t;

  // Unsigned maximum of two samples.
  function automatic logic [ADC_WIDTH-1:0] adc_max(input logic [ADC_WIDTH-1:0] a,
                                                   input logic [ADC_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/muon_buf_fifo.sv
// First-word-fall-through FIFO with a registered head. The storage array has
// no reset so it can map onto block RAM; the head register is loaded from the
// next read address, with a bypass when the word being written becomes the head.
module muon_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       CLK120,
  input  logic                       RESET_N,
  input  logic [WIDTH-1:0]           PUSH_DATA,
  input  logic                       PUSH,
  input  logic                       POP,
  output logic [WIDTH-1:0]           HEAD_DATA,
  output logic                       HEAD_VALID,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [$clog2(DEPTH):0]     COUNT
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic [WIDTH-1:0] head_data_reg;
  logic             head_valid_reg;
  logic             do_push, do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign EMPTY   = (wr_ptr_reg == rd_ptr_reg);
  assign FULL    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign COUNT   = wr_ptr_reg - rd_ptr_reg;
  assign do_pop  = POP && !EMPTY;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = PUSH && (!FULL || do_pop);

  assign wr_ptr_next = wr_ptr_reg + (AW+1)'(do_push);
  assign rd_ptr_next = rd_ptr_reg + (AW+1)'(do_pop);

  assign HEAD_DATA  = head_data_reg;
  assign HEAD_VALID = head_valid_reg;

  // Storage write port.
  always_ff @(posedge CLK120) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= PUSH_DATA;
    end
  end

  // Read/write pointer registers.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Registered head: holds still while no pop occurs.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      head_data_reg  <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      head_valid_reg <= (wr_ptr_next != rd_ptr_next);
      if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
        head_data_reg <= PUSH_DATA;
      end else begin
        head_data_reg <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/muon_event_buffer.sv
// Captures each muon trigger with a timestamp and per-channel peak amplitudes
// over a programmable window, and queues the records for readout.
module muon_event_buffer
  import muon_event_buffer_pkg::*;
#(
  parameter int DEPTH     = MUON_BUF_DEPTH,
  parameter int TS_WIDTH  = MUON_BUF_TS_WIDTH,
  parameter int WIN_WIDTH = MUON_BUF_WIN_WIDTH
) (
  input  logic                            CLK120,
  input  logic                            RESET_N,
  input  logic                            ENABLE,
  input  logic                            MUON_TRIG,
  input  logic [ADC_WIDTH-1:0]            ADC0,
  input  logic [ADC_WIDTH-1:0]            ADC1,
  input  logic [ADC_WIDTH-1:0]            ADC2,
  input  logic [ADC_WIDTH-1:0]            ADC_SSD,
  input  logic [WIN_WIDTH-1:0]            WIN_LEN,
  input  logic                            CLR_CNT,
  output logic [TS_WIDTH+4*ADC_WIDTH-1:0] OUT_DATA,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic [$clog2(DEPTH):0]          FIFO_COUNT,
  output logic [STAT_WIDTH-1:0]           DEAD_CNT,
  output logic [STAT_WIDTH-1:0]           OVFL_CNT
);

  localparam int REC_WIDTH = TS_WIDTH + 4*ADC_WIDTH;

  cap_state_t              state_reg, state_next;
  logic [TS_WIDTH-1:0]     ts_cnt_reg, ts_lat_reg;
  logic [WIN_WIDTH:0]      win_n_reg, samp_cnt_reg, samp_cnt_inc;
  logic [4*ADC_WIDTH-1:0]  adc_flat, peaks_flat;
  logic [STAT_WIDTH-1:0]   dead_cnt_reg, ovfl_cnt_reg;
  logic                    start, sample, write;
  logic                    fifo_full, fifo_empty, fifo_pop;
  logic                    dead_inc, ovfl_inc;

  assign adc_flat     = {ADC_SSD, ADC2, ADC1, ADC0};
  assign samp_cnt_inc = samp_cnt_reg + (WIN_WIDTH+1)'(1);
  assign fifo_pop     = !fifo_empty && OUT_READY;
  assign dead_inc     = MUON_TRIG && ENABLE && (state_reg != ST_IDLE);
  assign ovfl_inc     = write && fifo_full && !fifo_pop;
  assign DEAD_CNT     = dead_cnt_reg;
  assign OVFL_CNT     = ovfl_cnt_reg;

  // Capture FSM next state; a one-sample window goes straight to WRITE.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    sample     = 1'b0;
    write      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (MUON_TRIG && ENABLE) begin
          start      = 1'b1;
          state_next = (WIN_LEN == '0) ? ST_WRITE : ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        sample = 1'b1;
        if (samp_cnt_inc == win_n_reg) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        write      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Free-running timestamp plus per-capture latches (TS, window length, count).
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      ts_cnt_reg   <= '0;
      ts_lat_reg   <= '0;
      win_n_reg    <= '0;
      samp_cnt_reg <= '0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + TS_WIDTH'(1);
      if (start) begin
        ts_lat_reg   <= ts_cnt_reg;
        win_n_reg    <= {1'b0, WIN_LEN} + (WIN_WIDTH+1)'(1);
        samp_cnt_reg <= (WIN_WIDTH+1)'(1);
      end else if (sample) begin
        samp_cnt_reg <= samp_cnt_inc;
      end
    end
  end

  // One running-maximum register per channel, loaded with the trigger sample.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_peak
      logic [ADC_WIDTH-1:0] peak_reg;
      logic [ADC_WIDTH-1:0] adc_s;
      assign adc_s = adc_flat[gi*ADC_WIDTH +: ADC_WIDTH];
      always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N)    peak_reg <= '0;
        else if (start)  peak_reg <= adc_s;
        else if (sample) peak_reg <= adc_max(peak_reg, adc_s);
      end
      assign peaks_flat[gi*ADC_WIDTH +: ADC_WIDTH] = peak_reg;
    end
  endgenerate

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      dead_cnt_reg <= '0;
      ovfl_cnt_reg <= '0;
    end else if (CLR_CNT) begin
      dead_cnt_reg <= '0;
      ovfl_cnt_reg <= '0;
    end else begin
      if (dead_inc && (dead_cnt_reg != '1)) dead_cnt_reg <= dead_cnt_reg + STAT_WIDTH'(1);
      if (ovfl_inc && (ovfl_cnt_reg != '1)) ovfl_cnt_reg <= ovfl_cnt_reg + STAT_WIDTH'(1);
    end
  end

  muon_buf_fifo #(
    .WIDTH (REC_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK120     (CLK120),
    .RESET_N    (RESET_N),
    .PUSH_DATA  ({ts_lat_reg, peaks_flat}),
    .PUSH       (write),
    .POP        (fifo_pop),
    .HEAD_DATA  (OUT_DATA),
    .HEAD_VALID (OUT_VALID),
    .FULL       (fifo_full),
    .EMPTY      (fifo_empty),
    .COUNT      (FIFO_COUNT)
  );

endmodule
